servo_pwm_decoder: RTL and testbench

Receive-side counterpart of the servo PWM generator: measures the high time of a servo-style pulse train and recovers the 8-bit position code that produced it. It uses the same 3.9 µs tick and the same 140-tick offset and ×2 scaling, so generator output looped back into this block returns the original code. It sits between an external PWM source (loopback, RC receiver, test fixture) and position-consuming logic on the 50 MHz domain.

---
 rtl/servo_pkg.sv | 12 +
 rtl/sync_edge.sv | 39 +++
 rtl/servo_pwm_decoder.sv | 171 +++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Constants shared by the servo PWM generator and decoder so both ends agree on timing and code scaling.
package servo_pkg;

    localparam int unsigned CLK_DIV     = 195;
    localparam int unsigned INIT        = 140;
    localparam int unsigned FRAME_TICKS = 5129;
    localparam int unsigned MAX_HIGH    = 1023;
    localparam int unsigned POS_W       = 8;
    localparam int unsigned TICK_W      = 10;
    localparam int unsigned ARITH_W     = 11;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus one-cycle rise/fall pulses on the synchronized copy.
module sync_edge #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level  = sync_q;
    assign rise_c = sync_q & ~prev_q;
    assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high time in prescaled ticks and recovers the 8-bit position code, with error flags and a frame watchdog.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int unsigned CLK_DIV     = servo_pkg::CLK_DIV,
    parameter int unsigned INIT        = servo_pkg::INIT,
    parameter int unsigned FRAME_TICKS = servo_pkg::FRAME_TICKS,
    parameter int unsigned MAX_HIGH    = servo_pkg::MAX_HIGH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [POS_W-1:0]  pos,
    output logic              pos_valid,
    output logic [TICK_W-1:0] pulse_ticks,
    output logic              err_short,
    output logic              err_long,
    output logic              signal_lost
);

    localparam int unsigned PRE_W = $clog2(CLK_DIV);
    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned LOST  = 2 * FRAME_TICKS;
    localparam int unsigned WD_W  = $clog2(LOST + 1);

    typedef enum logic [1:0] {
        ST_ARM,
        ST_WAIT_RISE,
        ST_HIGH,
        ST_DONE
    } state_e;

    logic sync_lvl, rise_c, fall_c;

    // Reset the synchronizer high so an input already high at reset never looks like a fresh rising edge.
    sync_edge #(.RST_VAL(1'b1)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (pwm_in),
        .level    (sync_lvl),
        .rise_c   (rise_c),
        .fall_c   (fall_c)
    );

    state_e              state_q, state_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                pos_valid_q, pos_valid_d;
    logic [TICK_W-1:0]   pulse_ticks_q, pulse_ticks_d;
    logic                err_short_q, err_short_d;
    logic                err_long_q, err_long_d;
    logic [PRE_W-1:0]    wd_pre_q, wd_pre_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                signal_lost_q, signal_lost_d;
    logic                wd_tick_c;
    logic [ARITH_W-1:0]  raw_c;

    assign raw_c     = (ARITH_W'(tick_q) - ARITH_W'(INIT)) >> 1;
    assign wd_tick_c = (wd_pre_q == PRE_W'(CLK_DIV - 1));

    // Measurement FSM, result decode and free-running frame watchdog.
    always_comb begin
        state_d       = state_q;
        pre_d         = pre_q;
        tick_d        = tick_q;
        pos_d         = pos_q;
        pos_valid_d   = 1'b0;
        pulse_ticks_d = pulse_ticks_q;
        err_short_d   = err_short_q;
        err_long_d    = err_long_q;
        wd_pre_d      = wd_tick_c ? '0 : wd_pre_q + PRE_W'(1);
        wd_cnt_d      = wd_cnt_q;
        signal_lost_d = signal_lost_q;

        case (state_q)
            ST_ARM: begin
                if (!sync_lvl) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (rise_c) begin
                    state_d = ST_HIGH;
                    pre_d   = PRE_W'(HALF);
                    tick_d  = '0;
                end
            end
            ST_HIGH: begin
                // Abort wins over a coincident fall so tick_q never wraps.
                if (tick_q == TICK_W'(MAX_HIGH)) begin
                    err_long_d = 1'b1;
                    state_d    = ST_ARM;
                end else begin
                    if (pre_q == PRE_W'(CLK_DIV - 1)) begin
                        pre_d  = '0;
                        tick_d = tick_q + TICK_W'(1);
                    end else begin
                        pre_d  = pre_q + PRE_W'(1);
                    end
                    if (fall_c) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                pulse_ticks_d = tick_q;
                pos_valid_d   = 1'b1;
                state_d       = ST_WAIT_RISE;
                if (tick_q < TICK_W'(INIT)) begin
                    err_short_d = 1'b1;
                    err_long_d  = 1'b0;
                    pos_d       = '0;
                end else if (raw_c > ARITH_W'((1 << POS_W) - 1)) begin
                    err_short_d = 1'b0;
                    err_long_d  = 1'b1;
                    pos_d       = '1;
                end else begin
                    err_short_d = 1'b0;
                    err_long_d  = 1'b0;
                    pos_d       = POS_W'(raw_c);
                end
            end
            default: state_d = ST_ARM;
        endcase

        if (rise_c) begin
            wd_cnt_d = '0;
        end else if (wd_tick_c && (wd_cnt_q != WD_W'(LOST))) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end

        if (pos_valid_d) begin
            signal_lost_d = 1'b0;
        end else if (wd_cnt_q == WD_W'(LOST)) begin
            signal_lost_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ARM;
            pre_q         <= '0;
            tick_q        <= '0;
            pos_q         <= '0;
            pos_valid_q   <= 1'b0;
            pulse_ticks_q <= '0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            wd_pre_q      <= '0;
            wd_cnt_q      <= '0;
            signal_lost_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_q         <= pre_d;
            tick_q        <= tick_d;
            pos_q         <= pos_d;
            pos_valid_q   <= pos_valid_d;
            pulse_ticks_q <= pulse_ticks_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            wd_pre_q      <= wd_pre_d;
            wd_cnt_q      <= wd_cnt_d;
            signal_lost_q <= signal_lost_d;
        end
    end

    assign pos         = pos_q;
    assign pos_valid   = pos_valid_q;
    assign pulse_ticks = pulse_ticks_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with a short tick (5 clk) and short frame (600 ticks) to keep runs brief.
module tb_servo_pwm_decoder;

    localparam int unsigned DIV   = 5;
    localparam int unsigned FRAME = 600;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwm_in;
    logic [7:0] pos;
    logic       pos_valid;
    logic [9:0] pulse_ticks;
    logic       err_short;
    logic       err_long;
    logic       signal_lost;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;
    int s0;

    servo_pwm_decoder #(
        .CLK_DIV     (DIV),
        .FRAME_TICKS (FRAME)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .pos         (pos),
        .pos_valid   (pos_valid),
        .pulse_ticks (pulse_ticks),
        .err_short   (err_short),
        .err_long    (err_long),
        .signal_lost (signal_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pos_valid === 1'b1) strobes <= strobes + 1;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // High for hi clk cycles then low for lo cycles; edges launched on negedge.
    task automatic send_pulse(input int hi, input int lo);
        @(negedge clk) pwm_in = 1'b1;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulse_and_check(input string tag, input int hi, input int exp_ticks,
                                   input int exp_pos, input int exp_short, input int exp_long);
        int s;
        s = strobes;
        send_pulse(hi, 40);
        check_eq({tag, "_strobes"}, strobes - s, 1);
        check_eq({tag, "_ticks"}, int'(pulse_ticks), exp_ticks);
        check_eq({tag, "_pos"}, int'(pos), exp_pos);
        check_eq({tag, "_short"}, int'(err_short), exp_short);
        check_eq({tag, "_long"}, int'(err_long), exp_long);
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_pos", int'(pos), 0);
        check_eq("rst_valid", int'(pos_valid), 0);
        check_eq("rst_ticks", int'(pulse_ticks), 0);
        check_eq("rst_errs", int'({err_short, err_long, signal_lost}), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // ticks = floor((cycles + 2) / 5); pos = (ticks - 140) >> 1
        pulse_and_check("p0",      700,  140, 0,   0, 0);
        pulse_and_check("p100",    1700, 340, 100, 0, 0);
        pulse_and_check("p100_lo", 1698, 340, 100, 0, 0);
        pulse_and_check("p100_hi", 1702, 340, 100, 0, 0);
        pulse_and_check("round",   713,  143, 1,   0, 0);
        pulse_and_check("p255",    3250, 650, 255, 0, 0);
        pulse_and_check("over",    3500, 700, 255, 0, 1);
        pulse_and_check("p141",    705,  141, 0,   0, 0);
        pulse_and_check("short",   500,  100, 0,   1, 0);
        pulse_and_check("one_cyc", 1,    0,   0,   1, 0);
        check_eq("lost_early", int'(signal_lost), 0);

        // Stuck high past MAX_HIGH: abort without strobe, flags sticky.
        s0 = strobes;
        send_pulse(5500, 50);
        check_eq("stuck_hi_strobes", strobes - s0, 0);
        check_eq("stuck_hi_long", int'(err_long), 1);
        check_eq("stuck_hi_short", int'(err_short), 1);
        check_eq("stuck_hi_ticks", int'(pulse_ticks), 0);
        check_eq("stuck_hi_lost", int'(signal_lost), 0);

        // Stuck low: no rise for 1200 ticks since the last one.
        repeat (600) @(negedge clk);
        check_eq("lost_set", int'(signal_lost), 1);
        pulse_and_check("recover", 1700, 340, 100, 0, 0);
        check_eq("lost_clear", int'(signal_lost), 0);

        // Reset mid-pulse, input still high at release: that pulse must be ignored.
        s0 = strobes;
        @(negedge clk) pwm_in = 1'b1;
        repeat (500) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        pwm_in = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("midrst_strobes", strobes - s0, 0);
        check_eq("midrst_pos", int'(pos), 0);
        check_eq("midrst_ticks", int'(pulse_ticks), 0);
        check_eq("midrst_errs", int'({err_short, err_long, signal_lost}), 0);
        pulse_and_check("after_rst", 1700, 340, 100, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
